// File: rtl/bt_uart_tx.sv
// Bluetooth UART transmitter: byte FIFO behind a valid/ready port, serialised as 8N1
// frames LSB first on Tx, with back-to-back frames whenever the FIFO stays non-empty.
module bt_uart_tx #(
  parameter int CLK_FREQ   = 16000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          WF_CLK,
  input  logic                          WF_BUTTON,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          Tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_F = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_F-1:0] FIFO_FULL = CNT_F'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   baud_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               tx_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q;
  logic [PTR_W-1:0]   rptr_q;
  logic [CNT_F-1:0]   count_q;
  logic [CNT_F-1:0]   count_d;

  logic               push;
  logic               pop;
  logic               bit_end;
  logic               fifo_nempty;

  assign bit_end     = (baud_q == BAUD_LAST);
  assign fifo_nempty = (count_q != '0);

  // Gating with the reset pin drops tx_ready the instant the button goes low.
  assign tx_ready = (count_q != FIFO_FULL) && WF_BUTTON;
  assign push     = tx_valid && tx_ready;

  // A byte leaves the FIFO either from idle or at the last cycle of a stop bit.
  assign pop = fifo_nempty &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_F'(1);
      2'b01:   count_d = count_q - CNT_F'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge WF_CLK) begin
    if (push) mem_q[wptr_q] <= tx_data;
  end

  always_ff @(posedge WF_CLK) begin
    if (pop) begin
      shift_q <= mem_q[rptr_q];
    end else if ((state_q == S_DATA) && bit_end) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  // Tx is a register preset by the async reset, so an aborted frame returns high without a low glitch.
  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (pop) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
          end else begin
            tx_q    <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            baud_q  <= baud_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            bit_q  <= '0;
            if (pop) begin
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign Tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || fifo_nempty;
  assign fifo_count = count_q;

endmodule

// File: doc/bt_uart_tx.md
# bt_uart_tx

Bluetooth UART transmitter: accepts bytes over a valid/ready handshake, buffers them in a small FIFO and serialises them as 8N1 frames on the Bluetooth module's RX line (Tx, routed to ir_snsrch1 at the top level). It is the send-side counterpart of Rx_wrapper and runs on the 16 MHz board clock. It is instantiated beside Rx_wrapper in the Bluetooth top and replaces the constant `Tx = 1'b1` tie-off.

## Interface
- CLK_FREQ, 16000000: input clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. DIV = CLK_FREQ / BAUD, integer truncation (1666 at defaults). DIV >= 2 is required.
- FIFO_DEPTH, 4: byte buffer depth. Power of two, >= 2.
- WF_CLK  input  1  system clock; all state changes on its rising edge.
- WF_BUTTON  input  1  reset, asynchronous assert, active-low.
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  FIFO can accept a byte.
- Tx  output  1  serial line; idle high; registered.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  log2(FIFO_DEPTH)+1  bytes currently buffered.

## Operation
- Reset (WF_BUTTON low): Tx=1, state IDLE, FIFO empty, fifo_count=0, busy=0, tx_ready=0, baud counter=0, bit index=0. Any frame in progress is truncated and the line returns high immediately. After release, tx_ready=1.
- Push: at a rising edge with tx_valid && tx_ready, tx_data is written at the write pointer and count increments. tx_ready = (count != FIFO_DEPTH) && reset released. tx_ready is combinational from the registered count.
- Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave the count unchanged.
- FSM states:
  - IDLE: Tx=1. If count != 0: pop the head byte into an 8-bit shift register and go to START.
  - START: Tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: Tx = shift[0] (LSB first) for DIV cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: Tx=1 for DIV cycles. At the end: if count != 0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 within each bit and clears on every state change.
- Frame = 10 bits = 10*DIV cycles.
- Data path is fixed at 8N1: no parity, no flow control.
- busy = (state != IDLE) || (count != 0).

## Timing
- Push accepted at edge E0 with the FSM in IDLE and the FIFO empty:
  - count becomes 1 at E0.
  - Pop at E1: count returns to 0 and Tx goes 0 after E1.
  - Start bit spans E1..E1+DIV. Data bit n starts at E1+(n+1)*DIV. Stop bit starts at E1+9*DIV.
  - Tx is idle-high from E1+10*DIV, and busy falls then.
- Back-to-back: the next start bit begins exactly at E1+10*DIV when the FIFO is non-empty, giving continuous frames.
- Full FIFO: tx_ready=0, and tx_valid is ignored (no write, no overflow) even in a cycle where a pop occurs. tx_ready rises the cycle after the pop.
- Empty FIFO: no pop, FSM holds IDLE, Tx=1.
- Producer may hold tx_valid high continuously. Exactly one byte is taken per edge where tx_ready=1.
- Reset asserted mid-frame: Tx=1 asynchronously, with no glitch low. FIFO contents are discarded. The first frame after release starts only after a new push.

## Test plan
- Sim params CLK_FREQ=16, BAUD=1 (DIV=16). Single push 0xA5 at E0 -> Tx low over E1..E1+16, then bits 1,0,1,0,0,1,0,1 each 16 cycles, stop high 16 cycles. busy high from E0 to E1+160, then low.
- Push 0x00 then 0xFF on consecutive edges -> two frames with no gap: second start bit at E1+160. tx_ready stays 1 and fifo_count peaks at 1.
- Push 6 bytes 0x01..0x06 with tx_valid held high -> 0x01 pops after one cycle, so the next 4 bytes fill the FIFO: fifo_count=4, tx_ready=0. 0x06 waits until a pop frees a slot. All six bytes appear on Tx in order, none lost or duplicated.
- Assert WF_BUTTON low at cycle 40 of a frame with 2 bytes queued -> Tx=1, fifo_count=0, busy=0, tx_ready=0 immediately. After release, Tx stays high with no output until a new push.
- Default params, push 0x55 -> each bit period is exactly 1666 WF_CLK cycles and total frame length is 16660 cycles.
- tx_valid pulsed while tx_ready=0 (FIFO full) -> fifo_count unchanged and the byte never appears on Tx.
